// File: rtl/pc_update_seq.sv
// PC-update stage of the sequential Y86-64 core: picks valC/valM/valP by icode and Cnd, registers it.
// Optional halt freeze (halted flag + port) is enabled by defining PC_HALT_FREEZE_EN.
module pc_update_seq #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic        condition,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  input  logic [63:0] valP,
  output logic [63:0] next_PC,
`ifdef PC_HALT_FREEZE_EN
  output logic        halted,
`endif
  output logic [63:0] updated_PC
);

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  logic [63:0] w_next_pc;
  logic [63:0] r_pc;

  // Only call, taken jXX and ret redirect; everything else (incl. C-F) falls through.
  always_comb begin
    w_next_pc = valP;
    case (icode)
      ICALL:   w_next_pc = valC;
      IJXX:    w_next_pc = condition ? valC : valP;
      IRET:    w_next_pc = valM;
      default: w_next_pc = valP;
    endcase
  end

  assign next_PC    = w_next_pc;
  assign updated_PC = r_pc;

`ifdef PC_HALT_FREEZE_EN
  logic r_halted;

  // The halt edge still loads valP; only subsequent edges freeze until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      r_pc <= w_next_pc;
      if (icode == IHALT) r_halted <= 1'b1;
    end
  end

  assign halted = r_halted;
`else
  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_next_pc;
  end
`endif

endmodule

// File: tb/tb_pc_update_seq.sv
// Self-checking bench for pc_update_seq: directed cases then random traffic vs a behavioural model.
module tb_pc_update_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  icode;
  logic        condition;
  logic [63:0] valC, valM, valP;
  logic [63:0] next_PC, updated_PC;
`ifdef PC_HALT_FREEZE_EN
  logic        halted;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] m_pc;
  logic        m_halt;

  pc_update_seq #(.RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .icode(icode), .condition(condition),
    .valC(valC), .valM(valM), .valP(valP), .next_PC(next_PC),
`ifdef PC_HALT_FREEZE_EN
    .halted(halted),
`endif
    .updated_PC(updated_PC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Architectural rule: where the next instruction comes from.
  function automatic logic [63:0] ref_next(input logic [3:0] ic, input logic c,
                                           input logic [63:0] vc, input logic [63:0] vm,
                                           input logic [63:0] vp);
    if (ic == 4'h8)               return vc;
    if (ic == 4'h7)               return c ? vc : vp;
    if (ic == 4'h9)               return vm;
    return vp;
  endfunction

  task automatic step(input string tag, input logic rst, input logic [3:0] ic, input logic c,
                      input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp);
    logic [63:0] nx;
    @(negedge clk);
    reset = rst; icode = ic; condition = c; valC = vc; valM = vm; valP = vp;
    nx = ref_next(ic, c, vc, vm, vp);
    #1 chk({tag, ".next"}, next_PC, nx);
    @(posedge clk);
    if (rst) begin
      m_pc = 64'd0; m_halt = 1'b0;
    end else if (!m_halt) begin
      m_pc = nx;
`ifdef PC_HALT_FREEZE_EN
      if (ic == 4'h0) m_halt = 1'b1;
`endif
    end
    #1 chk({tag, ".pc"}, updated_PC, m_pc);
`ifdef PC_HALT_FREEZE_EN
    chk({tag, ".halted"}, {63'd0, halted}, {63'd0, m_halt});
`endif
  endtask

  initial begin
    reset = 1'b1; icode = 4'h0; condition = 1'b0; valC = '0; valM = '0; valP = '0;
    m_pc = '0; m_halt = 1'b0;

    step("reset",   1'b1, 4'h8, 1'b0, 64'd4460,  64'd0,     64'd0);
    step("deassert",1'b0, 4'h0, 1'b0, 64'd0,     64'd0,     64'd0);
    // halt just loaded valP; clear any freeze before the main directed set
    step("rst2",    1'b1, 4'h1, 1'b0, 64'd0,     64'd0,     64'd0);
    step("call",    1'b0, 4'h8, 1'b0, 64'd4460,  64'd0,     64'd10);
    step("ret",     1'b0, 4'h9, 1'b0, 64'd4460,  64'd22136, 64'd0);
    step("jtaken",  1'b0, 4'h7, 1'b1, 64'd39612, 64'd0,     64'd52719);
    step("jnot",    1'b0, 4'h7, 1'b0, 64'd39612, 64'd0,     64'd52719);
    step("opq",     1'b0, 4'h6, 1'b1, 64'd5,     64'd0,     64'd100);
    step("cmov",    1'b0, 4'h2, 1'b1, 64'd77,    64'd88,    64'd123);
    step("undefF",  1'b0, 4'hF, 1'b1, 64'd9,     64'd9,     64'd200);
    step("wide",    1'b0, 4'h8, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd1);
    step("midrst",  1'b1, 4'h9, 1'b1, 64'd1,     64'h8000_0000_0000_0001, 64'd2);
    step("halt",    1'b0, 4'h0, 1'b0, 64'd0,     64'd0,     64'd300);
    for (int i = 0; i < 3; i++)
      step("frz",   1'b0, 4'h8, 1'b1, 64'd4460,  64'd0,     64'd400);
    step("unhalt",  1'b1, 4'h8, 1'b0, 64'd4460,  64'd0,     64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] ic;
      ic = 4'($urandom_range(0, 15));
      step("rnd", ($urandom_range(0, 19) == 0), ic, 1'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_update_seq.md
Name: pc_update_seq

Overview:
- PC-update stage of the sequential (SEQ) Y86-64 processor.
- Selects the next program counter from valC, valM or valP, based on icode and the branch condition from execute.
- Registers the selected value as updated_PC on each rising clock edge; updated_PC feeds fetch for the next instruction.

Parameters:
- RESET_PC, 64'd0, value loaded into updated_PC while reset is asserted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- icode  input  4  instruction code of the current instruction.
- condition  input  1  branch condition (Cnd) from execute; only meaningful for jXX.
- valC  input  64  instruction constant word (jump/call destination).
- valM  input  64  value read from memory (return address for ret).
- valP  input  64  address of the sequentially next instruction.
- next_PC  output  64  combinational next-PC selection.
- updated_PC  output  64  registered program counter.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset.
- icode encodings:
  - 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq
  - 7 jXX, 8 call, 9 ret, A pushq, B popq
- next_PC selection, combinational, pure function of current inputs:
  - icode 8 (call): valC.
  - icode 7 (jXX) with condition=1: valC.
  - icode 7 (jXX) with condition=0: valP.
  - icode 9 (ret): valM.
  - All other icodes, including undefined C–F: valP.
  - condition is ignored for every icode except 7; cmovXX (icode 2) never redirects the PC.
- Register update on each rising clk edge:
  - reset=1: updated_PC <= RESET_PC. Reset has priority over all other inputs.
  - reset=0: updated_PC <= next_PC (subject to the optional feature below).
- Latency: inputs applied before edge N appear on updated_PC after edge N (one-cycle latency). There is no handshake; the register updates every cycle.
- Widths: all address paths are 64 bits. No arithmetic is performed; values are copied unmodified, with no truncation or sign extension.
- Power-up: updated_PC is undefined until the first edge. Either reset is asserted, or the first edge loads next_PC.
- Reset asserted mid-operation: the next edge forces RESET_PC regardless of icode. The first edge after reset deasserts loads next_PC normally.

Optional Feature:
- Macro: PC_HALT_FREEZE_EN.
- When defined:
  - An edge with icode=0 (halt) and reset=0 loads next_PC (valP) and sets an internal halted flag.
  - While halted=1, updated_PC holds its value on every edge, whatever icode, condition, valC, valM or valP are.
  - next_PC still reflects the current inputs.
  - Only reset clears halted; reset also loads RESET_PC.
  - Output halted (1 bit) is added to the port list.
- When not defined:
  - halt is treated like any other non-control-flow instruction (PC <= valP).
  - No halted flag or port exists.

Test Plan:
- Reset:
  - reset=1 for one edge with icode=8, valC=4460 -> updated_PC=RESET_PC (0).
  - Deassert reset, icode=0, valP=0 -> updated_PC=0.
- call: icode=8, valC=4460, valP=10 -> after the next edge, updated_PC=4460; next_PC=4460 before the edge.
- ret: icode=9, valM=22136, valC=4460 -> after the edge, updated_PC=22136.
- Jumps:
  - icode=7, condition=1, valC=39612, valP=52719 -> updated_PC=39612.
  - Same inputs with condition=0 -> updated_PC=52719.
- Sequential and undefined codes:
  - icode=6, condition=1, valC=5, valP=100 -> updated_PC=100 (condition ignored).
  - icode=F, valP=200 -> updated_PC=200.
- PC_HALT_FREEZE_EN:
  - icode=0, valP=300 -> updated_PC=300 and halted=1.
  - Then icode=8, valC=4460 for 3 edges -> updated_PC stays 300.
  - Then reset -> updated_PC=0 and halted=0.
